// File: rtl/stage_5_bitstream_buffer.sv
// Stage 5 of the entropy encoder: byte buffer between carry propagation and the
// output stream. Up to ten bytes per cycle are compacted into a circular FIFO
// and drained one byte at a time; the last byte of a frame is tagged.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for s5_flag_first; the first-cycle input is written
// ST_RUN    | accepting input; in_flag_last closes the frame
// ST_DRAIN  | input ignored; emptying the FIFO up to the tagged final byte
// ST_DONE   | one-cycle out_done pulse, then back to idle
module stage_5_bitstream_buffer #(
    parameter int S5_BITSTREAM_WIDTH = 8,
    parameter int S5_DEPTH           = 64,
    parameter int S5_ADDR_WIDTH      = 6
) (
    input  logic                          s5_clk,
    input  logic                          s5_reset_n,
    input  logic                          s5_flag_first,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_1_1,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_1_2,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_1_3,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_1_4,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_1_5,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_2_1,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_2_2,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_2_3,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_2_4,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_2_5,
    input  logic [2:0]                    in_carry_flag_1,
    input  logic [2:0]                    in_carry_flag_2,
    input  logic                          in_flag_last,
    input  logic                          out_ready,
    output logic [S5_BITSTREAM_WIDTH-1:0] out_byte,
    output logic                          out_valid,
    output logic                          out_last,
    output logic                          out_done,
    output logic [S5_ADDR_WIDTH:0]        out_level,
    output logic                          out_overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                    r_state;
    logic [1:0]                    w_state_next;
    logic [S5_BITSTREAM_WIDTH-1:0] r_mem [S5_DEPTH];
    logic [S5_ADDR_WIDTH-1:0]      r_wr_ptr;
    logic [S5_ADDR_WIDTH-1:0]      r_rd_ptr;
    logic [S5_ADDR_WIDTH-1:0]      r_last_ptr;
    logic [S5_ADDR_WIDTH-1:0]      w_last_ptr_next;
    logic [S5_ADDR_WIDTH:0]        r_count;
    logic [S5_ADDR_WIDTH:0]        w_count_next;
    logic [S5_ADDR_WIDTH:0]        w_free;
    logic                          r_overflow;
    logic [2:0]                    w_n1;
    logic [2:0]                    w_n2;
    logic [3:0]                    w_n;
    logic [S5_BITSTREAM_WIDTH-1:0] w_cat    [10];
    logic [S5_BITSTREAM_WIDTH-1:0] w_stream [10];
    logic                          w_wr_window;
    logic                          w_fits;
    logic                          w_accept;
    logic                          w_hs;

    // Flag values above five are clamped; set 2 follows set 1 in stream order.
    assign w_n1  = (in_carry_flag_1 > 3'd5) ? 3'd5 : in_carry_flag_1;
    assign w_n2  = (in_carry_flag_2 > 3'd5) ? 3'd5 : in_carry_flag_2;
    assign w_n   = {1'b0, w_n1} + {1'b0, w_n2};
    assign w_cat = '{in_carry_bit_1_1, in_carry_bit_1_2, in_carry_bit_1_3,
                     in_carry_bit_1_4, in_carry_bit_1_5,
                     in_carry_bit_2_1, in_carry_bit_2_2, in_carry_bit_2_3,
                     in_carry_bit_2_4, in_carry_bit_2_5};

    // Compaction: slot i takes set-1 byte i, or set-2 byte (i - n1) once set 1 is used up.
    always_comb begin
        logic [3:0] v_idx;
        v_idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            v_idx       = (4'(i) < {1'b0, w_n1}) ? 4'(i) : 4'(i) + 4'd5 - {1'b0, w_n1};
            w_stream[i] = (v_idx < 4'd10) ? w_cat[v_idx] : '0;
        end
    end

    // The full check uses the pre-edge count only; a same-cycle read does not make room.
    assign w_wr_window  = (r_state == ST_RUN) || ((r_state == ST_IDLE) && s5_flag_first);
    assign w_free       = (S5_ADDR_WIDTH+1)'(S5_DEPTH) - r_count;
    assign w_fits       = (S5_ADDR_WIDTH+1)'(w_n) <= w_free;
    assign w_accept     = w_wr_window && w_fits;
    assign w_hs         = out_valid && out_ready;
    assign w_count_next = r_count
                        + (w_accept ? (S5_ADDR_WIDTH+1)'(w_n) : '0)
                        - (S5_ADDR_WIDTH+1)'(w_hs);

    // Next-state and final-byte pointer selection.
    always_comb begin
        w_state_next    = r_state;
        w_last_ptr_next = r_last_ptr;
        case (r_state)
            ST_IDLE: begin
                if (s5_flag_first) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (in_flag_last) begin
                    // With nothing new accepted, the final byte is the youngest one already stored.
                    w_last_ptr_next = (w_accept && (w_n != 4'd0))
                                    ? r_wr_ptr + S5_ADDR_WIDTH'(w_n) - 1'b1
                                    : r_wr_ptr - 1'b1;
                    w_state_next    = (w_count_next == '0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_hs && out_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FIFO storage write; contents survive reset and are fenced off by the pointers.
    always_ff @(posedge s5_clk) begin
        if (w_accept) begin
            for (int i = 0; i < 10; i++) begin
                if (4'(i) < w_n) r_mem[r_wr_ptr + S5_ADDR_WIDTH'(i)] <= w_stream[i];
            end
        end
    end

    // Control state: FSM, pointers, occupancy and sticky overflow.
    always_ff @(posedge s5_clk or negedge s5_reset_n) begin
        if (!s5_reset_n) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_last_ptr <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_last_ptr <= w_last_ptr_next;
            r_count    <= w_count_next;
            if (w_accept) r_wr_ptr <= r_wr_ptr + S5_ADDR_WIDTH'(w_n);
            if (w_hs) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr_window && !w_fits) r_overflow <= 1'b1;
        end
    end

    // Output stream; out_byte is forced to zero while the FIFO is empty.
    assign out_valid    = (r_count != '0);
    assign out_byte     = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_last     = (r_state == ST_DRAIN) && out_valid && (r_rd_ptr == r_last_ptr);
    assign out_done     = (r_state == ST_DONE);
    assign out_level    = r_count;
    assign out_overflow = r_overflow;

endmodule

// File: tb/tb_stage_5_bitstream_buffer.sv
// Bench for the stage-5 bitstream buffer: a queue-based frame model is stepped on
// every clock edge and compared against the DUT outputs on the falling edge.
module tb_stage_5_bitstream_buffer;

    logic       s5_clk = 1'b0;
    logic       s5_reset_n = 1'b0;
    logic       r_first = 1'b0;
    logic       r_last = 1'b0;
    logic       r_ready = 1'b0;
    logic [2:0] r_f1 = 3'd0;
    logic [2:0] r_f2 = 3'd0;
    logic [7:0] r_s1 [5];
    logic [7:0] r_s2 [5];

    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_last;
    logic       out_done;
    logic [6:0] out_level;
    logic       out_overflow;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    byte unsigned m_q[$];
    bit           m_ovf;
    bit           m_frame;
    bit           m_drain;
    bit           m_done;
    int           m_to_last;

    always #5 s5_clk = ~s5_clk;

    stage_5_bitstream_buffer dut (
        .s5_clk           (s5_clk),
        .s5_reset_n       (s5_reset_n),
        .s5_flag_first    (r_first),
        .in_carry_bit_1_1 (r_s1[0]),
        .in_carry_bit_1_2 (r_s1[1]),
        .in_carry_bit_1_3 (r_s1[2]),
        .in_carry_bit_1_4 (r_s1[3]),
        .in_carry_bit_1_5 (r_s1[4]),
        .in_carry_bit_2_1 (r_s2[0]),
        .in_carry_bit_2_2 (r_s2[1]),
        .in_carry_bit_2_3 (r_s2[2]),
        .in_carry_bit_2_4 (r_s2[3]),
        .in_carry_bit_2_5 (r_s2[4]),
        .in_carry_flag_1  (r_f1),
        .in_carry_flag_2  (r_f2),
        .in_flag_last     (r_last),
        .out_ready        (r_ready),
        .out_byte         (out_byte),
        .out_valid        (out_valid),
        .out_last         (out_last),
        .out_done         (out_done),
        .out_level        (out_level),
        .out_overflow     (out_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf     = 0;
        m_frame   = 0;
        m_drain   = 0;
        m_done    = 0;
        m_to_last = 0;
    endtask

    // One clock edge of frame behaviour, from the pre-edge model state and inputs.
    task automatic model_step();
        int  n1, n2, n, pre;
        bit  hs;
        hs  = (m_q.size() != 0) && r_ready;
        n1  = (r_f1 > 5) ? 5 : int'(r_f1);
        n2  = (r_f2 > 5) ? 5 : int'(r_f2);
        n   = n1 + n2;
        pre = m_q.size();
        if (m_done) begin
            m_done  = 0;
            m_frame = 0;
            if (hs) void'(m_q.pop_front());
        end else if (m_drain) begin
            if (hs) begin
                void'(m_q.pop_front());
                m_to_last--;
                if (m_to_last == 0) begin
                    m_drain = 0;
                    m_done  = 1;
                end
            end
        end else begin
            if (m_frame || r_first) begin
                if (n <= 64 - pre) begin
                    for (int i = 0; i < n1; i++) m_q.push_back(r_s1[i]);
                    for (int i = 0; i < n2; i++) m_q.push_back(r_s2[i]);
                end else begin
                    m_ovf = 1;
                end
            end
            if (hs) void'(m_q.pop_front());
            if (m_frame && r_last) begin
                m_to_last = m_q.size();
                if (m_to_last == 0) m_done = 1;
                else m_drain = 1;
            end else if (!m_frame && r_first) begin
                m_frame = 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("valid", out_valid, m_q.size() != 0);
        chk("level", out_level, m_q.size());
        if (m_q.size() != 0) chk("byte", out_byte, m_q[0]);
        chk("last", out_last, m_drain && (m_to_last == 1) && (m_q.size() != 0));
        chk("done", out_done, m_done);
        chk("ovf", out_overflow, m_ovf);
    endtask

    task automatic tick();
        @(posedge s5_clk);
        if (s5_reset_n) model_step();
        @(negedge s5_clk);
        check_outputs();
    endtask

    task automatic set_in(input bit first, input int f1, input int f2, input bit last, input bit ready);
        r_first = first;
        r_f1    = 3'(f1);
        r_f2    = 3'(f2);
        r_last  = last;
        r_ready = ready;
        for (int i = 0; i < 5; i++) begin
            r_s1[i] = 8'($urandom);
            r_s2[i] = 8'($urandom);
        end
    endtask

    task automatic drain_all(input bit rand_ready);
        int cnt;
        cnt = 0;
        while ((m_q.size() != 0 || m_drain || m_done) && cnt < 400) begin
            set_in(0, 0, 0, 0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            tick();
            cnt++;
        end
        chk("drain_timeout", cnt < 400, 1);
    endtask

    initial begin
        int sent, cnt, n, n1, n2;
        model_reset();
        set_in(0, 0, 0, 0, 0);
        repeat (2) @(negedge s5_clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_level", out_level, 0);
        chk("rst_byte", out_byte, 0);
        chk("rst_ovf", out_overflow, 0);
        chk("rst_done", out_done, 0);
        s5_reset_n = 1'b1;

        // input in idle without first is ignored
        repeat (3) begin set_in(0, 5, 5, 0, 0); tick(); end
        chk("idle_level", out_level, 0);

        // frame of 3 + 2 bytes with ready high
        set_in(1, 3, 2, 0, 1);
        r_s1[0] = 8'hA0; r_s1[1] = 8'hA1; r_s1[2] = 8'hA2;
        r_s2[0] = 8'hB0; r_s2[1] = 8'hB1;
        tick();
        chk("t1_level", out_level, 5);
        chk("t1_head", out_byte, 8'hA0);
        drain_all(0);

        // close with n=0 on an empty FIFO: done on the next cycle, no out_last
        set_in(0, 0, 0, 1, 1);
        tick();
        chk("t5_done", out_done, 1);
        chk("t5_last", out_last, 0);
        set_in(0, 0, 0, 0, 1);
        tick();
        chk("t5_done_end", out_done, 0);

        // overflow: six n=10 cycles, a dropped seventh, then n=4 to full
        set_in(1, 5, 5, 0, 0); tick();
        repeat (5) begin set_in(0, 5, 5, 0, 0); tick(); end
        chk("t2_level60", out_level, 60);
        set_in(0, 5, 5, 0, 0); tick();
        chk("t2_drop_level", out_level, 60);
        chk("t2_ovf", out_overflow, 1);
        set_in(0, 2, 2, 0, 0); tick();
        chk("t2_full", out_level, 64);

        // close, drain to level 20, then async reset mid-drain
        set_in(0, 0, 0, 1, 0); tick();
        repeat (44) begin set_in(0, 0, 0, 0, 1); tick(); end
        chk("t6_level20", out_level, 20);
        #2 s5_reset_n = 1'b0;
        #1 chk("t6_async_valid", out_valid, 0);
        model_reset();
        set_in(0, 0, 0, 0, 1);
        tick(); tick();
        s5_reset_n = 1'b1;
        tick();
        chk("t6_level", out_level, 0);
        chk("t6_ovf", out_overflow, 0);

        // n=10 with last into exactly ten free entries
        set_in(1, 5, 5, 0, 0); tick();
        repeat (4) begin set_in(0, 5, 5, 0, 0); tick(); end
        set_in(0, 4, 0, 0, 0); tick();
        set_in(0, 5, 5, 1, 0); tick();
        chk("edge_full", out_level, 64);
        chk("edge_ovf", out_overflow, 0);
        drain_all(1);

        // 200-byte ramp with random ready, through pointer wrap
        set_in(1, 0, 0, 0, 0); tick();
        sent = 0; cnt = 0;
        while (sent < 200 && cnt < 3000) begin
            n = $urandom_range(0, 10);
            if (n > 200 - sent) n = 200 - sent;
            if (n > 64 - m_q.size()) n = 64 - m_q.size();
            n1 = $urandom_range((n > 5) ? n - 5 : 0, (n < 5) ? n : 5);
            n2 = n - n1;
            set_in(0, n1, n2, 0, 1'($urandom_range(0, 1)));
            for (int i = 0; i < n1; i++) r_s1[i] = 8'(sent + i);
            for (int i = 0; i < n2; i++) r_s2[i] = 8'(sent + n1 + i);
            sent += n;
            tick();
            cnt++;
        end
        chk("t3_sent", sent, 200);
        drain_all(1);
        chk("t3_ovf", out_overflow, 0);

        // last with n1=2 while level is 3
        set_in(0, 3, 0, 0, 0); tick();
        set_in(0, 2, 0, 1, 0); tick();
        chk("t4_level", out_level, 5);
        drain_all(0);
        tick();
        chk("t4_idle_level", out_level, 0);

        // flag 7 is clamped to 5
        set_in(1, 7, 0, 0, 0); tick();
        chk("t7_level", out_level, 5);
        drain_all(0);
        set_in(0, 0, 0, 1, 1); tick();
        drain_all(0);

        // random frames
        for (int k = 0; k < 800; k++) begin
            set_in($urandom_range(0, 15) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
            tick();
        end
        set_in(0, 0, 0, 1, 1); tick();
        drain_all(1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
